oq_rr_scheduler: RTL and testbench
==================================

# oq_rr_scheduler

Round-robin read scheduler for the SRAM output queues. It picks the next output queue to be drained from SRAM and hands that choice to the SRAM read engine. A queue is eligible when it is non-empty, send-enabled, and its destination port FIFO is ready. The block holds the grant until the read engine reports the packet removed, then advances the round-robin pointer past the served queue.

## Interface
- NUM_OUTPUT_QUEUES, 5: number of output queues scheduled.
- NUM_OQ_WIDTH, log2(NUM_OUTPUT_QUEUES): queue index width.
- TIMEOUT_CYCLES, 4096: BUSY watchdog limit; used only with OQ_SCHED_TIMEOUT_EN.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- oq_empty  in  NUM_OUTPUT_QUEUES  per-queue empty flag from the queue register helpers.
- enable_send_pkt  in  NUM_OUTPUT_QUEUES  per-queue send enable.
- dst_fifo_ready  in  NUM_OUTPUT_QUEUES  the destination port can accept a maximum-size packet.
- rd_req  out  1  read request to the SRAM read engine.
- rd_oq  out  NUM_OQ_WIDTH  queue being requested or served.
- rd_ack  in  1  read engine accepts the request.
- pkt_removed  in  1  pulse: a packet was fully removed.
- removed_pkt_oq  in  NUM_OQ_WIDTH  queue of the removed packet.
- sched_busy  out  1  high in REQ and BUSY.
- sched_timeout  out  1  one-cycle pulse when the watchdog fires.

## Operation
- eligible[i] = !oq_empty[i] && enable_send_pkt[i] && dst_fifo_ready[i].
- States are IDLE, REQ and BUSY, with a registered rr_ptr (reset value 0).
- IDLE:
  - If any eligible bit is set, select the first eligible index scanning rr_ptr, rr_ptr+1, …, wrapping from NUM_OUTPUT_QUEUES-1 to 0.
  - Register the selection into rd_oq, set rd_req=1, and go to REQ.
  - If nothing is eligible, stay in IDLE with rd_req=0.
- REQ:
  - Hold rd_req=1 and keep rd_oq stable until rd_ack.
  - On rd_ack: rd_req<=0 and go to BUSY.
  - If enable_send_pkt[rd_oq] drops without rd_ack: rd_req<=0, go to IDLE, rr_ptr unchanged (withdrawal).
  - rd_ack and the enable drop in the same cycle: the ack wins.
- BUSY:
  - Wait for pkt_removed && removed_pkt_oq==rd_oq.
  - Then rr_ptr <= (rd_oq==NUM_OUTPUT_QUEUES-1) ? 0 : rd_oq+1 and go to IDLE.
- pkt_removed for a different queue, or arriving in IDLE/REQ, is ignored.
- rd_oq holds its last value in IDLE; it is meaningful only while sched_busy=1.
- Changes to eligibility during BUSY have no effect.
- rr_ptr arithmetic is NUM_OQ_WIDTH-bit with an explicit wrap at NUM_OUTPUT_QUEUES (not at a power of two).

## Timing
- Reset values: rd_req=0, rd_oq=0, sched_busy=0, sched_timeout=0, state=IDLE, rr_ptr=0, watchdog=0.
- An asynchronous reset in any state returns everything to these values immediately.
- Eligible sampled in IDLE at cycle t → rd_req=1 at t+1.
- rd_ack at t → rd_req=0 at t+1.
- Matching pkt_removed at t → IDLE at t+1 → earliest next rd_req at t+2.
- The one IDLE cycle is mandatory: the oq_empty/oq_full flags from the helper lag by one cycle.
- Back-to-back grants to the same queue occur only if it is the sole eligible queue.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- OQ_SCHED_TIMEOUT_EN defined:
  - A watchdog counter (width log2(TIMEOUT_CYCLES)+1) clears on entry to BUSY and increments each BUSY cycle.
  - On reaching TIMEOUT_CYCLES-1 without a matching pkt_removed: sched_timeout pulses one cycle, rr_ptr advances past rd_oq, state goes to IDLE.
  - A matching pkt_removed in the same cycle as the timeout takes precedence; no pulse is generated.
- OQ_SCHED_TIMEOUT_EN undefined:
  - No watchdog logic; BUSY waits indefinitely.
  - sched_timeout is tied to 0.

## Structure
- Shared oq defines file holds the state encodings (OQ_SCHED_IDLE=0, OQ_SCHED_REQ=1, OQ_SCHED_BUSY=2) and OQ_SCHED_DEFAULT_TIMEOUT.
- Sub-module oq_rr_pick: a combinational rotating priority encoder.
  - Inputs: eligible and rr_ptr.
  - Outputs: pick_valid and pick_oq.
- The FSM, rr_ptr and watchdog stay in oq_rr_scheduler.

## Test plan
- Queues 1, 3 and 4 eligible, rr_ptr=0, rd_ack one cycle after each rd_req, pkt_removed 10 cycles after each ack → grant order 1, 3, 4, 1; rr_ptr=2 after the first removal.
- Only queue 4 eligible, served → rr_ptr wraps to 0; queue 4 granted again after the one-cycle IDLE gap.
- In REQ on queue 2, enable_send_pkt[2] drops with no ack → rd_req=0 next cycle, state IDLE, rr_ptr unchanged.
- In BUSY on queue 2: pkt_removed with removed_pkt_oq=3 is ignored; a later pkt_removed with removed_pkt_oq=2 → IDLE and rr_ptr=3.
- Reset asserted in BUSY between clock edges → rd_req, sched_busy and rr_ptr go to 0 before the next edge.
- With OQ_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, no pkt_removed → sched_timeout pulses on the 16th BUSY cycle, then the next eligible queue is granted. Without the macro → sched_busy stays 1 and sched_timeout stays 0.

Source files
------------

// File: rtl/oq_rr_scheduler_pkg.sv
// Shared definitions for the SRAM output-queue round-robin read scheduler.
// Holds the FSM state encodings and the default BUSY watchdog limit.
package oq_rr_scheduler_pkg;

  typedef enum logic [1:0] {
    OQ_SCHED_IDLE = 2'd0,
    OQ_SCHED_REQ  = 2'd1,
    OQ_SCHED_BUSY = 2'd2
  } oq_sched_state_t;

  localparam int OQ_SCHED_DEFAULT_TIMEOUT = 4096;
  localparam int OQ_SCHED_DEFAULT_QUEUES  = 5;

endpackage

// File: rtl/oq_rr_pick.sv
// Rotating priority encoder: first eligible queue at or after rr_ptr,
// wrapping at NUM_OUTPUT_QUEUES rather than at a power of two.
module oq_rr_pick
  import oq_rr_scheduler_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = OQ_SCHED_DEFAULT_QUEUES,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES)
) (
  input  logic [NUM_OUTPUT_QUEUES-1:0] eligible,
  input  logic [NUM_OQ_WIDTH-1:0]      rr_ptr,
  output logic                         pick_valid,
  output logic [NUM_OQ_WIDTH-1:0]      pick_oq
);

  localparam logic [NUM_OQ_WIDTH-1:0] LAST_OQ = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  // Walk the queues starting at rr_ptr and latch the first eligible index.
  always_comb begin
    logic [NUM_OQ_WIDTH-1:0] idx_s;
    pick_valid = 1'b0;
    pick_oq    = {NUM_OQ_WIDTH{1'b0}};
    if (rr_ptr > LAST_OQ) begin
      idx_s = {NUM_OQ_WIDTH{1'b0}};
    end else begin
      idx_s = rr_ptr;
    end
    for (int k = 0; k < NUM_OUTPUT_QUEUES; k++) begin
      if (!pick_valid && eligible[idx_s]) begin
        pick_valid = 1'b1;
        pick_oq    = idx_s;
      end else begin
        pick_oq    = pick_oq;
      end
      if (idx_s == LAST_OQ) begin
        idx_s = {NUM_OQ_WIDTH{1'b0}};
      end else begin
        idx_s = idx_s + NUM_OQ_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/oq_rr_scheduler.sv
// Round-robin read scheduler for the SRAM output queues (IDLE -> REQ -> BUSY).
// Optional BUSY watchdog is built only when OQ_SCHED_TIMEOUT_EN is defined.
module oq_rr_scheduler
  import oq_rr_scheduler_pkg::*;
#(
  parameter int NUM_OUTPUT_QUEUES = OQ_SCHED_DEFAULT_QUEUES,
  parameter int NUM_OQ_WIDTH      = $clog2(NUM_OUTPUT_QUEUES),
  parameter int TIMEOUT_CYCLES    = OQ_SCHED_DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_OUTPUT_QUEUES-1:0] oq_empty,
  input  logic [NUM_OUTPUT_QUEUES-1:0] enable_send_pkt,
  input  logic [NUM_OUTPUT_QUEUES-1:0] dst_fifo_ready,
  output logic                         rd_req,
  output logic [NUM_OQ_WIDTH-1:0]      rd_oq,
  input  logic                         rd_ack,
  input  logic                         pkt_removed,
  input  logic [NUM_OQ_WIDTH-1:0]      removed_pkt_oq,
  output logic                         sched_busy,
  output logic                         sched_timeout
);

  localparam logic [NUM_OQ_WIDTH-1:0] LAST_OQ = NUM_OQ_WIDTH'(NUM_OUTPUT_QUEUES - 1);

  oq_sched_state_t               state_r;
  logic [NUM_OQ_WIDTH-1:0]       rr_ptr_r;
  logic [NUM_OQ_WIDTH-1:0]       next_ptr_s;
  logic [NUM_OUTPUT_QUEUES-1:0]  eligible_s;
  logic                          pick_valid_s;
  logic [NUM_OQ_WIDTH-1:0]       pick_oq_s;
  logic                          removed_match_s;

  assign eligible_s      = ~oq_empty & enable_send_pkt & dst_fifo_ready;
  assign removed_match_s = pkt_removed && (removed_pkt_oq == rd_oq);
  assign next_ptr_s      = (rd_oq == LAST_OQ) ? {NUM_OQ_WIDTH{1'b0}} : rd_oq + NUM_OQ_WIDTH'(1);

`ifdef OQ_SCHED_TIMEOUT_EN
  localparam int                WD_W     = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0]              wd_r;
`else
  assign sched_timeout = 1'b0;
`endif

  oq_rr_pick #(
    .NUM_OUTPUT_QUEUES (NUM_OUTPUT_QUEUES),
    .NUM_OQ_WIDTH      (NUM_OQ_WIDTH)
  ) u_pick (
    .eligible   (eligible_s),
    .rr_ptr     (rr_ptr_r),
    .pick_valid (pick_valid_s),
    .pick_oq    (pick_oq_s)
  );

  // Scheduler FSM with registered outputs, round-robin pointer and watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= OQ_SCHED_IDLE;
      rr_ptr_r   <= {NUM_OQ_WIDTH{1'b0}};
      rd_req     <= 1'b0;
      rd_oq      <= {NUM_OQ_WIDTH{1'b0}};
      sched_busy <= 1'b0;
`ifdef OQ_SCHED_TIMEOUT_EN
      wd_r          <= {WD_W{1'b0}};
      sched_timeout <= 1'b0;
`endif
    end else begin
`ifdef OQ_SCHED_TIMEOUT_EN
      sched_timeout <= 1'b0;
`endif
      case (state_r)
        OQ_SCHED_IDLE: begin
          if (pick_valid_s) begin
            rd_oq      <= pick_oq_s;
            rd_req     <= 1'b1;
            sched_busy <= 1'b1;
            state_r    <= OQ_SCHED_REQ;
          end else begin
            rd_req     <= 1'b0;
            sched_busy <= 1'b0;
          end
        end
        OQ_SCHED_REQ: begin
          // An ack in the same cycle as an enable drop still commits the read.
          if (rd_ack) begin
            rd_req  <= 1'b0;
            state_r <= OQ_SCHED_BUSY;
`ifdef OQ_SCHED_TIMEOUT_EN
            wd_r    <= {WD_W{1'b0}};
`endif
          end else if (!enable_send_pkt[rd_oq]) begin
            rd_req     <= 1'b0;
            sched_busy <= 1'b0;
            state_r    <= OQ_SCHED_IDLE;
          end else begin
            rd_req <= 1'b1;
          end
        end
        OQ_SCHED_BUSY: begin
          if (removed_match_s) begin
            rr_ptr_r   <= next_ptr_s;
            sched_busy <= 1'b0;
            state_r    <= OQ_SCHED_IDLE;
`ifdef OQ_SCHED_TIMEOUT_EN
          end else if (wd_r == WD_LIMIT) begin
            sched_timeout <= 1'b1;
            rr_ptr_r      <= next_ptr_s;
            sched_busy    <= 1'b0;
            state_r       <= OQ_SCHED_IDLE;
          end else begin
            wd_r <= wd_r + WD_W'(1);
`else
          end else begin
            sched_busy <= 1'b1;
`endif
          end
        end
        default: begin
          state_r    <= OQ_SCHED_IDLE;
          rd_req     <= 1'b0;
          sched_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oq_rr_scheduler.sv
// Self-checking bench for oq_rr_scheduler: directed vector table, multi-cycle
// sequences, and randomized traffic against a transaction-level reference model.
module tb_oq_rr_scheduler;

  localparam int N  = 5;
  localparam int W  = 3;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] oq_empty;
  logic [N-1:0] enable_send_pkt;
  logic [N-1:0] dst_fifo_ready;
  logic         rd_req;
  logic [W-1:0] rd_oq;
  logic         rd_ack;
  logic         pkt_removed;
  logic [W-1:0] removed_pkt_oq;
  logic         sched_busy;
  logic         sched_timeout;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state: request/busy flags, granted queue, pointer, watchdog.
  int m_busy, m_req, m_q, m_ptr, m_cnt, m_to;

  typedef struct {
    logic [N-1:0] empty;
    logic [N-1:0] en;
    logic [N-1:0] rdy;
    logic         ack;
    logic         rem;
    logic [W-1:0] rem_oq;
    logic         exp_req;
    logic [W-1:0] exp_oq;
    logic         exp_busy;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  oq_rr_scheduler #(
    .NUM_OUTPUT_QUEUES (N),
    .NUM_OQ_WIDTH      (W),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .oq_empty        (oq_empty),
    .enable_send_pkt (enable_send_pkt),
    .dst_fifo_ready  (dst_fifo_ready),
    .rd_req          (rd_req),
    .rd_oq           (rd_oq),
    .rd_ack          (rd_ack),
    .pkt_removed     (pkt_removed),
    .removed_pkt_oq  (removed_pkt_oq),
    .sched_busy      (sched_busy),
    .sched_timeout   (sched_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    oq_empty        = 5'b11111;
    enable_send_pkt = 5'b11111;
    dst_fifo_ready  = 5'b11111;
    rd_ack          = 1'b0;
    pkt_removed     = 1'b0;
    removed_pkt_oq  = 3'd0;
  endtask

  task automatic do_reset();
    quiet_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    m_busy = 0; m_req = 0; m_q = 0; m_ptr = 0; m_cnt = 0; m_to = 0;
  endtask

  task automatic wait_req(input string name, output logic [W-1:0] oq);
    bit ok = 1'b0;
    oq = 3'd7;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (rd_req) begin
        ok = 1'b1;
        oq = rd_oq;
      end else begin
        step();
      end
    end
    if (!ok) begin
      n_checks++;
      n_err++;
      $display("FAIL %s: rd_req never rose within 20 cycles", name);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] e, input logic [N-1:0] en, input logic [N-1:0] r,
                              input logic a, input logic rm, input logic [W-1:0] rq,
                              input logic xr, input logic [W-1:0] xq, input logic xb);
    vec_t v;
    v.empty = e; v.en = en; v.rdy = r; v.ack = a; v.rem = rm; v.rem_oq = rq;
    v.exp_req = xr; v.exp_oq = xq; v.exp_busy = xb;
    return v;
  endfunction

  function automatic bit elig(input int i);
    return !oq_empty[i] && enable_send_pkt[i] && dst_fifo_ready[i];
  endfunction

  // Advances the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    int hit;
    m_to = 0;
    if (m_busy == 0) begin
      hit = -1;
      for (int k = 0; k < N; k++) begin
        int i = (m_ptr + k) % N;
        if (hit < 0 && elig(i)) hit = i;
      end
      if (hit >= 0) begin
        m_q = hit; m_req = 1; m_busy = 1;
      end
    end else if (m_req != 0) begin
      if (rd_ack) begin
        m_req = 0; m_cnt = 0;
      end else if (!enable_send_pkt[m_q]) begin
        m_req = 0; m_busy = 0;
      end
    end else if (pkt_removed && int'(removed_pkt_oq) == m_q) begin
      m_ptr = (m_q + 1) % N; m_busy = 0;
`ifdef OQ_SCHED_TIMEOUT_EN
    end else if (m_cnt == TO - 1) begin
      m_to = 1; m_ptr = (m_q + 1) % N; m_busy = 0;
    end else begin
      m_cnt++;
`endif
    end
  endtask

  initial begin
    logic [W-1:0] g;
    int exp_order[4];
    int to_at;
    bit busy_ok, to_ok;
    exp_order[0] = 1; exp_order[1] = 3; exp_order[2] = 4; exp_order[3] = 1;

    do_reset();
    chk("reset rd_req", rd_req, 0);
    chk("reset rd_oq", rd_oq, 0);
    chk("reset sched_busy", sched_busy, 0);
    chk("reset sched_timeout", sched_timeout, 0);

    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 0, 0, 0, 1, 4, 1));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 0, 1, 3, 0, 4, 1));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 0, 1, 4, 0, 0, 0));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 0, 0, 0, 1, 4, 1));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 1, 0, 0, 0, 4, 1));
    tbl.push_back(mk(5'b01111, 5'b11111, 5'b11111, 0, 1, 4, 0, 0, 0));
    tbl.push_back(mk(5'b11011, 5'b11111, 5'b11111, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(5'b11011, 5'b11011, 5'b11111, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 0, 0, 0, 1, 2, 1));
    tbl.push_back(mk(5'b10011, 5'b11011, 5'b11111, 1, 0, 0, 0, 2, 1));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 0, 1, 3, 0, 2, 1));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 0, 0, 0, 1, 3, 1));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 1, 0, 0, 0, 3, 1));
    tbl.push_back(mk(5'b10011, 5'b11111, 5'b11111, 0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11011, 0, 0, 0, 1, 1, 1));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 0, 1, 1, 1, 1, 1));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(5'b11001, 5'b11111, 5'b11111, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b11111, 5'b11111, 5'b11111, 0, 0, 0, 0, 0, 0));

    for (int r = 0; r < tbl.size(); r++) begin
      oq_empty        = tbl[r].empty;
      enable_send_pkt = tbl[r].en;
      dst_fifo_ready  = tbl[r].rdy;
      rd_ack          = tbl[r].ack;
      pkt_removed     = tbl[r].rem;
      removed_pkt_oq  = tbl[r].rem_oq;
      step();
      chk($sformatf("vec%0d rd_req", r), rd_req, tbl[r].exp_req);
      chk($sformatf("vec%0d sched_busy", r), sched_busy, tbl[r].exp_busy);
      if (tbl[r].exp_busy) chk($sformatf("vec%0d rd_oq", r), rd_oq, tbl[r].exp_oq);
    end

    // Queues 1, 3, 4 eligible: ack one cycle after request, removal ten cycles after ack.
    do_reset();
    oq_empty = 5'b00101;
    for (int n = 0; n < 4; n++) begin
      wait_req($sformatf("order%0d wait", n), g);
      chk($sformatf("order%0d grant", n), g, exp_order[n]);
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
      chk($sformatf("order%0d req drop", n), rd_req, 0);
      repeat (9) step();
      pkt_removed    = 1'b1;
      removed_pkt_oq = g;
      step();
      pkt_removed = 1'b0;
      chk($sformatf("order%0d idle gap", n), sched_busy, 0);
    end

    // Asynchronous reset in BUSY clears outputs before the next edge.
    wait_req("async wait", g);
    chk("async pre grant", g, 3);
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    step();
    #3 reset = 1'b1;
    #1;
    chk("async rd_req", rd_req, 0);
    chk("async sched_busy", sched_busy, 0);
    chk("async rd_oq", rd_oq, 0);
    #2 reset = 1'b0;
    step();
    wait_req("async post wait", g);
    chk("async rr_ptr cleared", g, 1);

    // Hold BUSY without any removal.
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    busy_ok = 1'b1;
    to_ok   = 1'b1;
    to_at   = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (sched_timeout && to_at < 0) to_at = i;
      if (to_at < 0 && !sched_busy) busy_ok = 1'b0;
      if (sched_timeout !== 1'b0 && i != to_at) to_ok = 1'b0;
    end
`ifdef OQ_SCHED_TIMEOUT_EN
    chk("watchdog pulse cycle", to_at, TO);
    chk("watchdog single pulse", to_ok, 1);
    chk("watchdog busy before fire", busy_ok, 1);
    wait_req("watchdog regrant", g);
    chk("watchdog next grant", g, 3);
`else
    chk("no watchdog busy held", busy_ok, 1);
    chk("no watchdog timeout", to_at, -1);
    chk("no watchdog sched_busy", sched_busy, 1);
`endif

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      oq_empty        = N'($urandom & $urandom);
      enable_send_pkt = N'($urandom | $urandom | $urandom);
      dst_fifo_ready  = N'($urandom | $urandom);
      rd_ack          = ($urandom_range(0, 2) == 0);
      pkt_removed     = ($urandom_range(0, 3) == 0);
      removed_pkt_oq  = ($urandom_range(0, 1) == 0) ? W'(m_q) : W'($urandom_range(0, N - 1));
      model_edge();
      step();
      chk($sformatf("rand%0d rd_req", c), rd_req, m_req);
      chk($sformatf("rand%0d sched_busy", c), sched_busy, m_busy);
      chk($sformatf("rand%0d sched_timeout", c), sched_timeout, m_to);
      if (m_busy != 0) chk($sformatf("rand%0d rd_oq", c), rd_oq, m_q);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
